// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the segmented pipelined adder.
// Latency: n/a (package). Backpressure: n/a.
// Provides the add/subtract opcode encoding and the stage-count function.
package adder_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   function automatic int seg_count(input int w, input int m);
      return w / m;
   endfunction

endpackage

// File: rtl/seg_add_stage.sv
// One M-bit segment add with its stage register; stage K of S.
// Latency: 1 cycle. Backpressure: holds all state while en is low.
// Optional SEG_PIPE_ADDER_OVF_EN adds a signed-overflow register to the last stage.
module seg_add_stage
   import adder_pkg::*;
#(
   parameter int W = 32,
   parameter int M = 8,
   parameter int K = 0,
   parameter int S = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         prev_vld,
   input  logic [W-1:0] prev_acc,
   input  logic [W-1:0] prev_b,
   input  logic         prev_c,
   output logic         vld,
   output logic [W-1:0] acc,
   output logic [W-1:0] b,
   output logic         c,
   output logic         ovf
);

   localparam bit LAST = (K == S - 1);

   logic [M:0] seg_sum;

   // The current operand segment always sits in the low M bits: acc rotates the
   // finished sum segment in at the top while b shifts its consumed segment out.
   assign seg_sum = {1'b0, prev_acc[M-1:0]} + {1'b0, prev_b[M-1:0]} + {{M{1'b0}}, prev_c};

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= 1'b0;
         acc <= '0;
         b   <= '0;
         c   <= 1'b0;
      end else if (en) begin
         vld <= prev_vld;
         acc <= (prev_acc >> M) | (W'(seg_sum[M-1:0]) << (W - M));
         b   <= LAST ? '0 : (prev_b >> M);
         c   <= seg_sum[M];
      end
   end

`ifdef SEG_PIPE_ADDER_OVF_EN
   // Only the last stage sees the sign bits of a and b' in its low segment.
   if (LAST) begin : g_ovf
      always_ff @(posedge clk) begin
         if (rst) begin
            ovf <= 1'b0;
         end else if (en) begin
            ovf <= (prev_acc[M-1] == prev_b[M-1]) && (seg_sum[M-1] != prev_acc[M-1]);
         end
      end
   end else begin : g_no_ovf
      assign ovf = 1'b0;
   end
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: rtl/seg_pipe_adder.sv
// Segmented pipelined W-bit add/subtract; carry ripples one M-bit segment per stage.
// Latency: S = W/M cycles, one op per cycle. Backpressure: whole pipe stalls when out_valid && !out_ready.
// Optional macro SEG_PIPE_ADDER_OVF_EN enables the signed-overflow output.
module seg_pipe_adder
   import adder_pkg::*;
#(
   parameter int W = 32,
   parameter int M = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         c_in,
   input  logic         op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] s,
   output logic         c_out,
   output logic         ovf
);

   localparam int S = seg_count(W, M);

   if (W % M != 0) begin : g_bad_width
      $error("seg_pipe_adder: W must be a multiple of M");
   end

   logic         en;
   logic         vld_p [0:S];
   logic [W-1:0] acc_p [0:S];
   logic [W-1:0] b_p   [0:S];
   logic         c_p   [0:S];
   logic         ovf_p [0:S-1];

   // Bubbles are not collapsed: every stage advances together or not at all.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   assign vld_p[0] = in_valid;
   assign acc_p[0] = a;
   assign b_p[0]   = (op_e'(op) == OP_SUB) ? ~b : b;
   assign c_p[0]   = c_in;

   for (genvar k = 0; k < S; k++) begin : g_stage
      seg_add_stage #(
         .W (W),
         .M (M),
         .K (k),
         .S (S)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .prev_vld (vld_p[k]),
         .prev_acc (acc_p[k]),
         .prev_b   (b_p[k]),
         .prev_c   (c_p[k]),
         .vld      (vld_p[k+1]),
         .acc      (acc_p[k+1]),
         .b        (b_p[k+1]),
         .c        (c_p[k+1]),
         .ovf      (ovf_p[k])
      );
   end

   assign out_valid = vld_p[S];
   assign s         = acc_p[S];
   assign c_out     = c_p[S];
   assign ovf       = ovf_p[S-1];

endmodule

// File: doc/seg_pipe_adder.md
# seg_pipe_adder

Segmented, pipelined W-bit add/subtract unit with valid/ready flow control; successor to the combinational and fixed-register adders used by the multiplier's final carry-propagate stage. Operands are split into M-bit segments, and the carry ripples one segment per pipeline stage, so the critical path is one M-bit adder regardless of W. It accepts one operation per cycle, stalls cleanly under downstream backpressure, and adds a subtract mode.

## Interface
- `W`, 32, operand/result width; must be a multiple of `M`.
- `M`, 8, segment width; S = W/M is the stage count and the latency.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input operation present.
- `in_ready`  out  1  unit can accept this cycle.
- `a`, `b`  in  W  operands.
- `c_in`  in  1  carry into bit 0.
- `op`  in  1  0 = add, 1 = subtract (b inverted).
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts this cycle.
- `s`  out  W  result.
- `c_out`  out  1  carry out of bit W-1.
- `ovf`  out  1  signed overflow (see Configuration).

## Operation
- Arithmetic: {c_out, s} = a + (op ? ~b : b) + c_in, computed modulo 2^(W+1).
  - Plain subtract a-b requires op=1 with c_in=1; in that case c_out=1 means no borrow.
- Stage k (0..S-1):
  - adds segment k of the operands plus the registered carry from stage k-1 (stage 0 uses c_in);
  - registers the completed low segments, the carry, and the still-unprocessed upper operand segments;
  - all stages carry a valid bit.
- Global advance: en = !out_valid || out_ready. `in_ready` = en, derived combinationally.
- Transfers:
  - input transfer = in_valid && in_ready;
  - output transfer = out_valid && out_ready.
- When en=1, every stage shifts forward one position, and stage 0 loads the input if it is transferred, otherwise a bubble (valid=0).
- When en=0, all stage registers hold. `s`, `c_out` and `ovf` stay stable while out_valid=1 and out_ready=0.
- Bubbles are not collapsed. Throughput is one op per cycle while out_ready is held high.

## Timing
- Latency is S cycles.
  - An op accepted at edge t appears with out_valid=1 after edge t+S-1, i.e. it is visible in the cycle following the S-th edge counting the accept edge.
  - W=32, M=8: four cycles.
- Reset values: out_valid=0, s=0, c_out=0, ovf=0, all stage valids=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight ops; no output transfer occurs for them.
- Simultaneous output transfer and input transfer in the same cycle is legal; the pipeline stays full at full rate.
- in_valid=1 while in_ready=0: the input is not taken, and the source must hold it.
- S=1 (M=W) degenerates to a single registered adder with the same handshake.

## Configuration
- `SEG_PIPE_ADDER_OVF_EN` defined:
  - `ovf` = (a[W-1] == b'[W-1]) && (s[W-1] != a[W-1]), where b' is the possibly inverted b;
  - the sign bits needed for this are carried through the stages.
- Not defined: `ovf` is tied to 0 and no sign-bit registers are generated.

## Structure
- Shared package `adder_pkg`:
  - `op_e` enum (OP_ADD=0, OP_SUB=1);
  - function computing S from W and M.
- One sub-module, `seg_add_stage`: one M-bit segment add plus its stage register and valid bit, with parameters for its position k.
- Top level instantiates S stages in a generate loop and holds the handshake logic.
- Elaboration-time assertion that W % M == 0.

## Test plan
All scenarios use W=32, M=8.
- Reset, then idle: out_valid=0, s=0, c_out=0, in_ready=1.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, c_in=0, op=0 → after 4 cycles s=0x00000000, c_out=1.
- Subtract: a=0x00000005, b=0x00000007, c_in=1, op=1 → s=0xFFFFFFFE, c_out=0.
  - With `SEG_PIPE_ADDER_OVF_EN`: a=0x7FFFFFFF, b=0x00000001, op=0, c_in=0 → ovf=1.
- Back-to-back stream: 100 random ops, in_valid=1 and out_ready=1 → 100 results, in order, one per cycle, matching the reference model.
- Backpressure: out_ready randomly deasserted for 30% of cycles → no loss or duplication, outputs held stable while stalled, and in_ready low exactly when out_valid=1 && out_ready=0.
- Reset asserted with 3 ops in flight → no out_valid after reset. The next op accepted is the first result produced.
